// File: rtl/rpn_stack_ctrl.sv
// RPN keypad controller: operand stack, register file, start/ready handshake to an add/sub unit.
// Multi-digit operand entry is enabled by defining RPN_DIGIT_ACCUM_EN.
module rpn_stack_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREGS = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [3:0]       tecla_i,
  input  logic             tecla_valid_i,
  input  logic [WIDTH-1:0] calcresult_i,
  input  logic             overflow_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             ok_o,
  output logic             key_o,
  output logic             busy_o,
  output logic             calc_start_o,
  output logic             subtract_o
);

  localparam int unsigned IdxW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StErr} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [WIDTH-1:0] regs_q  [NREGS];
  logic [WIDTH-1:0] regs_d  [NREGS];
  logic             ok_q, ok_d, key_q, key_d, lift_q, lift_d;
  logic             sub_q, sub_d, first_q, first_d;

  logic [IdxW-1:0]  addr;
  logic             addr_ok;
  logic [WIDTH+3:0] accum;
  logic             accum_ovf;
  logic             go_err;
  logic             do_push;

  assign addr      = stack_q[0][IdxW-1:0];
  assign addr_ok   = 32'(stack_q[0]) < NREGS;
  assign accum     = (WIDTH+4)'(stack_q[0]) * (WIDTH+4)'(10) + (WIDTH+4)'(tecla_i);
  assign accum_ovf = |accum[WIDTH+3:WIDTH];

  always_comb begin
    state_d = state_q;
    stack_d = stack_q;
    regs_d  = regs_q;
    ok_d    = ok_q;
    key_d   = key_q;
    lift_d  = lift_q;
    sub_d   = sub_q;
    first_d = 1'b0;
    go_err  = 1'b0;
    do_push = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tecla_valid_i) begin
          unique case (tecla_i)
            4'hA, 4'hB: begin
              state_d = StCalc;
              sub_d   = (tecla_i == 4'hB);
              first_d = 1'b1;
            end
            4'hC: begin
              if (!addr_ok) begin
                go_err = 1'b1;
              end else begin
                regs_d[addr] = stack_q[1];
                key_d        = 1'b1;
                lift_d       = 1'b1;
              end
            end
            4'hD: begin
              if (!addr_ok) begin
                go_err = 1'b1;
              end else begin
                stack_d[0] = regs_q[addr];
                key_d      = 1'b1;
                lift_d     = 1'b1;
              end
            end
            4'hE: begin
              do_push = 1'b1;
              key_d   = 1'b1;
              lift_d  = 1'b0;
            end
            4'hF: begin
              stack_d[0] = '0;
              key_d      = 1'b1;
              lift_d     = 1'b0;
            end
            default: begin
`ifdef RPN_DIGIT_ACCUM_EN
              if (!key_q) begin
                if (accum_ovf) go_err = 1'b1;
                else stack_d[0] = accum[WIDTH-1:0];
              end else begin
                do_push    = lift_q;
                stack_d[0] = WIDTH'(tecla_i);
                key_d      = 1'b0;
                lift_d     = 1'b0;
              end
`else
              // Without accumulation a pending digit is a finished number, so it gets pushed.
              do_push    = lift_q | ~key_q;
              stack_d[0] = WIDTH'(tecla_i);
              key_d      = 1'b0;
              lift_d     = 1'b0;
`endif
            end
          endcase
        end
      end
      StCalc: begin
        if (!first_q && ready_i) begin
          if (overflow_i) begin
            go_err = 1'b1;
          end else begin
            stack_d[0] = calcresult_i;
            for (int i = 1; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
            stack_d[DEPTH-1] = '0;
            key_d   = 1'b1;
            lift_d  = 1'b1;
            sub_d   = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StErr: begin
        if (tecla_valid_i && tecla_i == 4'hF) begin
          for (int i = 0; i < DEPTH; i++) stack_d[i] = '0;
          ok_d    = 1'b1;
          key_d   = 1'b1;
          lift_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_push) begin
      for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
    end

    if (go_err) begin
      for (int i = 0; i < DEPTH; i++) stack_d[i] = '1;
      ok_d    = 1'b0;
      key_d   = 1'b1;
      lift_d  = 1'b0;
      sub_d   = 1'b0;
      state_d = StErr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      ok_q    <= 1'b1;
      key_q   <= 1'b1;
      lift_q  <= 1'b0;
      sub_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stack_q <= stack_d;
      regs_q  <= regs_d;
      ok_q    <= ok_d;
      key_q   <= key_d;
      lift_q  <= lift_d;
      sub_q   <= sub_d;
      first_q <= first_d;
    end
  end

  assign a_o          = stack_q[1];
  assign b_o          = stack_q[0];
  assign ok_o         = ok_q;
  assign key_o        = key_q;
  assign busy_o       = (state_q == StCalc);
  assign calc_start_o = (state_q == StCalc) && first_q;
  assign subtract_o   = sub_q;

endmodule
